// File: rtl/demux_reg_bank.sv
// Routes incoming words into a bank of CHANNELS output registers, either by
// explicit select or by an auto-incrementing fill pointer, and reports when every channel is loaded.
module demux_reg_bank #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      auto_mode,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  output logic                      all_loaded,
  output logic [SEL_W-1:0]          wr_ptr,
  output logic                      err
);

  typedef enum logic {LOADING = 1'b0, FULL = 1'b1} state_t;

  localparam logic [SEL_W:0]   CH_COUNT = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

  state_t               state_reg;
  logic [CHANNELS-1:0]  valid_reg;
  logic [CHANNELS-1:0]  valid_next;
  logic [CHANNELS-1:0]  wr_en;
  logic [SEL_W-1:0]     ptr_reg;
  logic [SEL_W-1:0]     tgt;
  logic                 accept;
  logic                 tgt_ok;
  logic                 overwrite;
  logic                 all_loaded_reg;
  logic                 err_reg;
  logic [WIDTH-1:0]     data_reg [CHANNELS];

  // in_ready includes rst_n so nothing can look acceptable while reset is held.
  always_comb begin
    in_ready   = rst_n && (state_reg == LOADING) && !clear;
    accept     = in_valid && in_ready;
    tgt        = auto_mode ? ptr_reg : sel;
    tgt_ok     = ({1'b0, tgt} < CH_COUNT);
    overwrite  = |(wr_en & valid_reg);
    valid_next = valid_reg | wr_en;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign wr_en[gi] = accept && tgt_ok && (tgt == SEL_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg[gi] <= '0;
      end else if (wr_en[gi]) begin
        data_reg[gi] <= in_data;
      end
    end

    assign out_data[gi*WIDTH +: WIDTH] = data_reg[gi];
  end

  // Control: clear wins over any pending word; err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= LOADING;
      valid_reg      <= '0;
      ptr_reg        <= '0;
      all_loaded_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else if (clear) begin
      state_reg      <= LOADING;
      valid_reg      <= '0;
      ptr_reg        <= '0;
      all_loaded_reg <= 1'b0;
    end else if (accept) begin
      valid_reg <= valid_next;
      if (auto_mode) begin
        ptr_reg <= (ptr_reg == LAST_CH) ? '0 : ptr_reg + SEL_W'(1);
      end
      if (!tgt_ok || overwrite) begin
        err_reg <= 1'b1;
      end
      if (&valid_next) begin
        state_reg      <= FULL;
        all_loaded_reg <= 1'b1;
      end
    end
  end

  assign out_valid  = valid_reg;
  assign wr_ptr     = ptr_reg;
  assign all_loaded = all_loaded_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_demux_reg_bank.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with the
// cycle they apply to; a monitor pops and compares them on the falling edge.
module tb_demux_reg_bank;

  logic        clk;
  logic        rst_n;
  int          cyc = 0;

  logic [7:0]  d0_in, d1_in;
  logic        v0_in, v1_in, am0, am1, cl0, cl1;
  logic [1:0]  s0, s1;
  logic        rdy0, rdy1, full0, full1, err0, err1;
  logic [31:0] data0;
  logic [23:0] data1;
  logic [3:0]  val0;
  logic [2:0]  val1;
  logic [1:0]  ptr0, ptr1;

  demux_reg_bank #(.WIDTH(8), .CHANNELS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0_in), .in_valid(v0_in), .in_ready(rdy0),
    .sel(s0), .auto_mode(am0), .clear(cl0), .out_data(data0), .out_valid(val0),
    .all_loaded(full0), .wr_ptr(ptr0), .err(err0)
  );

  demux_reg_bank #(.WIDTH(8), .CHANNELS(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1_in), .in_valid(v1_in), .in_ready(rdy1),
    .sel(s1), .auto_mode(am1), .clear(cl1), .out_data(data1), .out_valid(val1),
    .all_loaded(full1), .wr_ptr(ptr1), .err(err1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          dut;
    bit          rdy_only;
    string       name;
    logic [31:0] data;
    logic [3:0]  valid;
    logic        full;
    logic [1:0]  ptr;
    logic        err;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor
  initial begin
    exp_t        e;
    logic [31:0] a_data;
    logic [3:0]  a_valid;
    logic        a_full, a_err, a_rdy;
    logic [1:0]  a_ptr;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e       = q.pop_front();
        a_data  = (e.dut == 0) ? data0 : {8'h00, data1};
        a_valid = (e.dut == 0) ? val0  : {1'b0, val1};
        a_full  = (e.dut == 0) ? full0 : full1;
        a_ptr   = (e.dut == 0) ? ptr0  : ptr1;
        a_err   = (e.dut == 0) ? err0  : err1;
        a_rdy   = (e.dut == 0) ? rdy0  : rdy1;
        total++;
        if (e.cyc < cyc) begin
          bad++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
        end else if (e.rdy_only) begin
          if (a_rdy !== e.rdy) begin
            bad++;
            $display("FAIL %s: in_ready got %b want %b", e.name, a_rdy, e.rdy);
          end else begin
            $display("cyc %0d dut%0d %s: in_ready=%b ok", cyc, e.dut, e.name, a_rdy);
          end
        end else if (a_data !== e.data || a_valid !== e.valid || a_full !== e.full ||
                     a_ptr !== e.ptr || a_err !== e.err) begin
          bad++;
          $display("FAIL %s: got data=%h valid=%b full=%b ptr=%0d err=%b want data=%h valid=%b full=%b ptr=%0d err=%b",
                   e.name, a_data, a_valid, a_full, a_ptr, a_err,
                   e.data, e.valid, e.full, e.ptr, e.err);
        end else begin
          $display("cyc %0d dut%0d %s: data=%h valid=%b full=%b ptr=%0d err=%b ok",
                   cyc, e.dut, e.name, a_data, a_valid, a_full, a_ptr, a_err);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic am, input logic cl);
    v0_in = v; d0_in = d; s0 = s; am0 = am; cl0 = cl;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic [1:0] s,
                      input logic am, input logic cl);
    v1_in = v; d1_in = d; s1 = s; am1 = am; cl1 = cl;
  endtask

  // off = 1: state after the next rising edge; off = 0: state in the current cycle.
  task automatic exp_st(input int dut, input int off, input string nm, input logic [31:0] d,
                        input logic [3:0] v, input logic f, input logic [1:0] p, input logic e);
    exp_t x;
    x.cyc = cyc + off; x.dut = dut; x.rdy_only = 1'b0; x.name = nm;
    x.data = d; x.valid = v; x.full = f; x.ptr = p; x.err = e; x.rdy = 1'b0;
    q.push_back(x);
  endtask

  task automatic exp_rdy(input int dut, input string nm, input logic r);
    exp_t x;
    x.cyc = cyc; x.dut = dut; x.rdy_only = 1'b1; x.name = nm;
    x.data = '0; x.valid = '0; x.full = 1'b0; x.ptr = '0; x.err = 1'b0; x.rdy = r;
    q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0;
    set0(1'b1, 8'h11, 2'd0, 1'b1, 1'b0);
    set1(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tick;
    tick;
    exp_rdy(0, "reset_ready", 1'b0);
    exp_st(0, 0, "reset_state", 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0);
    exp_st(1, 0, "reset_state_c3", 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Release with a word already waiting: first edge after release accepts it.
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_st(0, 1, "auto_first", 32'h0000_0011, 4'b0001, 1'b0, 2'd1, 1'b0);

    tick; exp_rdy(0, "rdy_loading", 1'b1);
    set0(1'b1, 8'h22, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "auto_second", 32'h0000_2211, 4'b0011, 1'b0, 2'd2, 1'b0);
    tick; set0(1'b1, 8'h33, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "auto_third", 32'h0033_2211, 4'b0111, 1'b0, 2'd3, 1'b0);
    tick; set0(1'b1, 8'h44, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "auto_full", 32'h4433_2211, 4'b1111, 1'b1, 2'd0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      tick; set0(1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
      exp_rdy(0, "rdy_full", 1'b0);
      exp_st(0, 1, "full_hold", 32'h4433_2211, 4'b1111, 1'b1, 2'd0, 1'b0);
    end

    tick; set0(1'b1, 8'h55, 2'd0, 1'b1, 1'b1);
    exp_rdy(0, "rdy_clear", 1'b0);
    exp_st(0, 1, "clear_full", 32'h4433_2211, 4'b0000, 1'b0, 2'd0, 1'b0);
    tick; set0(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    exp_rdy(0, "rdy_after_clear", 1'b1);
    exp_st(0, 1, "idle_after_clear", 32'h4433_2211, 4'b0000, 1'b0, 2'd0, 1'b0);

    tick; set0(1'b1, 8'hA5, 2'd2, 1'b0, 1'b0);
    exp_st(0, 1, "direct_sel2", 32'h44A5_2211, 4'b0100, 1'b0, 2'd0, 1'b0);
    tick; set0(1'b1, 8'h5A, 2'd0, 1'b0, 1'b0);
    exp_st(0, 1, "direct_sel0", 32'h44A5_225A, 4'b0101, 1'b0, 2'd0, 1'b0);
    tick; set0(1'b1, 8'hC3, 2'd2, 1'b0, 1'b0);
    exp_st(0, 1, "overwrite_sel2", 32'h44C3_225A, 4'b0101, 1'b0, 2'd0, 1'b1);

    tick; set0(1'b1, 8'h77, 2'd3, 1'b1, 1'b0);
    exp_st(0, 1, "auto_after_direct", 32'h44C3_2277, 4'b0101, 1'b0, 2'd1, 1'b1);
    tick; set0(1'b1, 8'h66, 2'd1, 1'b0, 1'b0);
    exp_st(0, 1, "direct_keeps_ptr", 32'h44C3_6677, 4'b0111, 1'b0, 2'd1, 1'b1);
    tick; set0(1'b1, 8'h99, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "auto_resume", 32'h44C3_9977, 4'b0111, 1'b0, 2'd2, 1'b1);
    tick; set0(1'b1, 8'h88, 2'd3, 1'b0, 1'b0);
    exp_st(0, 1, "direct_full", 32'h88C3_9977, 4'b1111, 1'b1, 2'd2, 1'b1);

    tick; set0(1'b1, 8'hBB, 2'd0, 1'b0, 1'b1);
    exp_rdy(0, "rdy_collide_full", 1'b0);
    exp_st(0, 1, "clear_collide_full", 32'h88C3_9977, 4'b0000, 1'b0, 2'd0, 1'b1);
    tick; set0(1'b1, 8'hBB, 2'd0, 1'b0, 1'b1);
    exp_rdy(0, "rdy_collide_load", 1'b0);
    exp_st(0, 1, "clear_collide_load", 32'h88C3_9977, 4'b0000, 1'b0, 2'd0, 1'b1);

    tick; set0(1'b1, 8'h12, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "refill_ch0", 32'h88C3_9912, 4'b0001, 1'b0, 2'd1, 1'b1);
    tick; set0(1'b1, 8'h34, 2'd0, 1'b1, 1'b0);
    exp_st(0, 1, "refill_ch1", 32'h88C3_3412, 4'b0011, 1'b0, 2'd2, 1'b1);
    tick; set0(1'b0, 8'h00, 2'd0, 1'b1, 1'b0);

    // Reset between edges: outputs must already be zero at the falling edge.
    tick;
    #1 rst_n = 1'b0;
    #1;
    set0(1'b1, 8'hAB, 2'd0, 1'b1, 1'b0);
    exp_rdy(0, "rdy_in_reset", 1'b0);
    exp_st(0, 0, "async_reset", 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0);
    exp_st(1, 0, "async_reset_c3", 32'h0, 4'b0000, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_st(0, 1, "restart_ch0", 32'h0000_00AB, 4'b0001, 1'b0, 2'd1, 1'b0);

    // Three-channel instance: out-of-range select and non-power-of-two fill.
    tick; set0(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h5C, 2'd3, 1'b0, 1'b0);
    exp_rdy(1, "rdy_c3", 1'b1);
    exp_st(1, 1, "oor_sel3", 32'h0, 4'b0000, 1'b0, 2'd0, 1'b1);
    tick; set1(1'b1, 8'h7E, 2'd2, 1'b0, 1'b0);
    exp_st(1, 1, "c3_sel2", 32'h007E_0000, 4'b0100, 1'b0, 2'd0, 1'b1);
    tick; set1(1'b1, 8'h01, 2'd0, 1'b1, 1'b0);
    exp_st(1, 1, "c3_auto0", 32'h007E_0001, 4'b0101, 1'b0, 2'd1, 1'b1);
    tick; set1(1'b1, 8'h02, 2'd0, 1'b1, 1'b0);
    exp_st(1, 1, "c3_full", 32'h007E_0201, 4'b0111, 1'b1, 2'd2, 1'b1);
    tick; set1(1'b1, 8'h03, 2'd0, 1'b1, 1'b0);
    exp_rdy(1, "rdy_c3_full", 1'b0);
    exp_st(1, 1, "c3_full_hold", 32'h007E_0201, 4'b0111, 1'b1, 2'd2, 1'b1);
    tick; set1(1'b0, 8'h00, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 20 && q.size() > 0; i++) tick;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
